// File: rtl/timer_pkg.sv
// Shared definitions for the player's timer blocks: digit widths and limits,
// the countdown FSM encoding and digit clamping / conversion helpers.
package timer_pkg;

  localparam int MAX_SECONDS = 599;
  localparam int DIGIT_W     = 6;
  localparam int SEC_W       = 10;

  localparam logic [DIGIT_W-1:0] MIN0_MAX = 6'd9;
  localparam logic [DIGIT_W-1:0] SEC1_MAX = 6'd5;
  localparam logic [DIGIT_W-1:0] SEC0_MAX = 6'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_RUN     = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d,
    input logic [DIGIT_W-1:0] lim
  );
    return (d > lim) ? lim : d;
  endfunction

  // Digits are clamped first, so the largest result is 9*60+59 = 599.
  function automatic logic [SEC_W-1:0] digits_to_seconds(
    input logic [DIGIT_W-1:0] m,
    input logic [DIGIT_W-1:0] s1,
    input logic [DIGIT_W-1:0] s0
  );
    return SEC_W'(m) * 10'd60 + SEC_W'(s1) * 10'd10 + SEC_W'(s0);
  endfunction

endpackage

// File: rtl/seconds_to_digits.sv
// Combinational conversion of a seconds count into minute / tens / units
// digits in the same encoding the elapsed-time Timer drives into driver7seg.
module seconds_to_digits
  import timer_pkg::*;
(
  input  logic [SEC_W-1:0]   seconds,
  output logic [DIGIT_W-1:0] minutes0,
  output logic [DIGIT_W-1:0] seconds1,
  output logic [DIGIT_W-1:0] seconds0
);

  logic [SEC_W-1:0] sec_in_min;

  assign sec_in_min = seconds % 10'd60;
  assign minutes0   = DIGIT_W'(seconds / 10'd60);
  assign seconds1   = DIGIT_W'(sec_in_min / 10'd10);
  assign seconds0   = DIGIT_W'(seconds % 10'd10);

endmodule

// File: rtl/countdown_timer.sv
// Remaining-time countdown: loads m:ss, subtracts `step` seconds per enabled
// edge, saturates at 0:00. Optional macro COUNTDOWN_AUTORELOAD_EN restarts from
// the loaded value instead of stopping when the time runs out.
module countdown_timer #(
  parameter int MAX_SECONDS = timer_pkg::MAX_SECONDS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [timer_pkg::DIGIT_W-1:0] load_minutes0,
  input  logic [timer_pkg::DIGIT_W-1:0] load_seconds1,
  input  logic [timer_pkg::DIGIT_W-1:0] load_seconds0,
  input  logic                          count,
  input  logic [timer_pkg::DIGIT_W-1:0] step,
  output logic [timer_pkg::DIGIT_W-1:0] minutes0,
  output logic [timer_pkg::DIGIT_W-1:0] seconds1,
  output logic [timer_pkg::DIGIT_W-1:0] seconds0,
  output logic                          running,
  output logic                          done,
  output logic                          expired
);

  import timer_pkg::*;

  state_e             state_q, state_d;
  logic [SEC_W-1:0]   remaining_q, remaining_d;
  logic [SEC_W-1:0]   reload_q, reload_d;
  logic               expired_q, expired_d;
  logic [DIGIT_W-1:0] min_q, min_d, s1_q, s1_d, s0_q, s0_d;

  logic [SEC_W-1:0] load_raw, load_value, dec_value;

  assign load_raw = digits_to_seconds(clamp_digit(load_minutes0, MIN0_MAX),
                                      clamp_digit(load_seconds1, SEC1_MAX),
                                      clamp_digit(load_seconds0, SEC0_MAX));
  assign load_value = (load_raw > SEC_W'(MAX_SECONDS)) ? SEC_W'(MAX_SECONDS) : load_raw;
  assign dec_value  = (remaining_q > SEC_W'(step)) ? remaining_q - SEC_W'(step) : '0;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    expired_d   = 1'b0;
    if (load) begin
      // Load takes the edge outright: no decrement, and 0:00 never pulses.
      remaining_d = load_value;
      reload_d    = load_value;
      state_d     = (load_value == '0) ? ST_EXPIRED : ST_PAUSE;
    end else if (count && (state_q == ST_PAUSE || state_q == ST_RUN)) begin
      if (dec_value == '0) begin
        expired_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        if (reload_q != '0) begin
          remaining_d = reload_q;
          state_d     = ST_RUN;
        end else begin
          remaining_d = '0;
          state_d     = ST_EXPIRED;
        end
`else
        remaining_d = '0;
        state_d     = ST_EXPIRED;
`endif
      end else begin
        remaining_d = dec_value;
        state_d     = ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end
  end

  // Convert the next value so the digit registers update on the same edge.
  seconds_to_digits u_conv (
    .seconds  (remaining_d),
    .minutes0 (min_d),
    .seconds1 (s1_d),
    .seconds0 (s0_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      expired_q   <= 1'b0;
      min_q       <= '0;
      s1_q        <= '0;
      s0_q        <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      expired_q   <= expired_d;
      min_q       <= min_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
    end
  end

  assign minutes0 = min_q;
  assign seconds1 = s1_q;
  assign seconds0 = s0_q;
  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_EXPIRED);
  assign expired  = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table plus hand sequences,
// expected outputs queued when stimulus is driven and popped after each edge.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, load, count;
  logic [5:0] load_minutes0, load_seconds1, load_seconds0, step;
  logic [5:0] minutes0, seconds1, seconds0;
  logic       running, done, expired;

  always #5 clk = ~clk;

  countdown_timer dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .load_minutes0 (load_minutes0),
    .load_seconds1 (load_seconds1),
    .load_seconds0 (load_seconds0),
    .count         (count),
    .step          (step),
    .minutes0      (minutes0),
    .seconds1      (seconds1),
    .seconds0      (seconds0),
    .running       (running),
    .done          (done),
    .expired       (expired)
  );

  typedef struct packed {
    logic [5:0] m, s1, s0;
    logic       r, d, e;
  } exp_t;

  typedef struct {
    logic       ld;
    logic [5:0] m, s1, s0;
    logic       cnt;
    logic [5:0] stp;
    int         rep;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic exp_t mk_exp(int secs, bit r, bit d, bit e);
    exp_t x;
    x.m  = 6'(secs / 60);
    x.s1 = 6'((secs % 60) / 10);
    x.s0 = 6'(secs % 10);
    x.r  = r;
    x.d  = d;
    x.e  = e;
    return x;
  endfunction

  function automatic vec_t v(bit ld, int m, int s1, int s0, bit cnt, int stp, int rep,
                             int esecs, bit er, bit ed, bit ee);
    vec_t x;
    x.ld  = ld;
    x.m   = 6'(m);
    x.s1  = 6'(s1);
    x.s0  = 6'(s0);
    x.cnt = cnt;
    x.stp = 6'(stp);
    x.rep = rep;
    x.exp = mk_exp(esecs, er, ed, ee);
    return x;
  endfunction

  task automatic compare(input string name);
    exp_t e, act;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, no expected value queued", name);
      return;
    end
    e   = sb.pop_front();
    act = {minutes0, seconds1, seconds0, running, done, expired};
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d:%0d%0d run=%b done=%b exp=%b, want %0d:%0d%0d run=%b done=%b exp=%b",
               name, act.m, act.s1, act.s0, act.r, act.d, act.e,
               e.m, e.s1, e.s0, e.r, e.d, e.e);
    end
  endtask

  task automatic cyc(input bit ld, input logic [5:0] m, input logic [5:0] s1,
                     input logic [5:0] s0, input bit cnt, input logic [5:0] stp,
                     input exp_t e, input string name);
    @(negedge clk);
    load          = ld;
    load_minutes0 = m;
    load_seconds1 = s1;
    load_seconds0 = s0;
    count         = cnt;
    step          = stp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; count = 1'b1; step = 6'd1;
    load_minutes0 = 6'd0; load_seconds1 = 6'd0; load_seconds0 = 6'd0;

    // Reset held with count high
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk_exp(0, 0, 0, 0));
    compare("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 0, 0, 1, 1, mk_exp(0, 0, 0, 0), $sformatf("idle%0d", i));

    // Basic countdown from 1:30, load and count both high on the load edge
    cyc(1, 1, 3, 0, 1, 1, mk_exp(90, 0, 0, 0), "load_130");
    for (int i = 1; i <= 90; i++) begin
      exp_t e;
`ifdef COUNTDOWN_AUTORELOAD_EN
      e = (i < 90) ? mk_exp(90 - i, 1, 0, 0) : mk_exp(90, 1, 0, 1);
`else
      e = (i < 90) ? mk_exp(90 - i, 1, 0, 0) : mk_exp(0, 0, 1, 1);
`endif
      cyc(0, 0, 0, 0, 1, 1, e, $sformatf("basic%0d", i));
    end
    for (int k = 1; k <= 3; k++) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      cyc(0, 0, 0, 0, 1, 1, mk_exp(90 - k, 1, 0, 0), $sformatf("after_zero%0d", k));
`else
      cyc(0, 0, 0, 0, 1, 1, mk_exp(0, 0, 1, 0), $sformatf("after_zero%0d", k));
`endif
    end

    // Pause and resume
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 1, 60, 0, 0, 0));
    for (int k = 1; k <= 5; k++) tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 60 - k, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 20, 55, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 54, 1, 0, 0));
    // Large step with saturation
    tbl.push_back(v(1, 0, 4, 0, 0, 15, 1, 40, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 15, 1, 25, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 15, 1, 10, 1, 0, 0));
`ifdef COUNTDOWN_AUTORELOAD_EN
    tbl.push_back(v(0, 0, 0, 0, 1, 15, 1, 40, 1, 0, 1));
    for (int k = 1; k <= 3; k++) tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 40 - k, 1, 0, 0));
`else
    tbl.push_back(v(0, 0, 0, 0, 1, 15, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0));
`endif
    // Load priority over count while running
    tbl.push_back(v(1, 0, 5, 0, 0, 1, 1, 50, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 49, 1, 0, 0));
    tbl.push_back(v(1, 2, 0, 0, 1, 1, 1, 120, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 119, 1, 0, 0));
    // Step of zero keeps RUN without changing the value
    tbl.push_back(v(1, 0, 0, 5, 0, 1, 1, 5, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 3, 5, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0));
    // Digit clamping and maximum step
    tbl.push_back(v(1, 12, 7, 12, 0, 63, 1, 599, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 63, 1, 536, 1, 0, 0));
    // Loading 0:00 goes straight to EXPIRED without a pulse
    tbl.push_back(v(1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0));
    // Load out of EXPIRED, short run to zero
    tbl.push_back(v(1, 0, 0, 3, 0, 1, 1, 3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 2, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0));
`ifdef COUNTDOWN_AUTORELOAD_EN
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 3, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 2, 1, 0, 0));
`else
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0));
`endif

    for (int i = 0; i < tbl.size(); i++)
      for (int r = 0; r < tbl[i].rep; r++)
        cyc(tbl[i].ld, tbl[i].m, tbl[i].s1, tbl[i].s0, tbl[i].cnt, tbl[i].stp,
            tbl[i].exp, $sformatf("vec%0d_%0d", i, r));

    // Asynchronous reset in the middle of a run
    cyc(1, 0, 5, 0, 0, 1, mk_exp(50, 0, 0, 0), "mid_load");
    cyc(0, 0, 0, 0, 1, 1, mk_exp(49, 1, 0, 0), "mid_run");
    #3;
    reset = 1'b0;
    #1;
    sb.push_back(mk_exp(0, 0, 0, 0));
    compare("async_reset");
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 1, 1, mk_exp(0, 0, 0, 0), "post_reset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Remaining-time counterpart of the elapsed-time `Timer`. It takes a track duration in minute:tens:units digit form and counts it down to 0:00 by a programmable number of seconds per enabled clock. It raises a one-cycle `expired` pulse and a level `done` when the time runs out. Its digit outputs use the same encoding as `Timer`, so they drive `driver7seg` directly in the player's display path.

## Interface
Parameters:
- `MAX_SECONDS`, default 599: largest representable remaining time, which is 9:59.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  when high, captures the `load_*` digits on the next edge; has priority over `count`.
- `load_minutes0`  in  6  minutes digit to load (valid range 0..9).
- `load_seconds1`  in  6  tens-of-seconds digit to load (valid range 0..5).
- `load_seconds0`  in  6  units-of-seconds digit to load (valid range 0..9).
- `count`  in  1  level enable; decrements on every edge where it is high.
- `step`  in  6  seconds subtracted per enabled edge (0..63).
- `minutes0`, `seconds1`, `seconds0`  out  6 each  remaining-time digits, registered.
- `running`  out  1  high while in RUN.
- `done`  out  1  high while in EXPIRED.
- `expired`  out  1  one-cycle pulse when the remaining time reaches 0.

## Operation
- Internal state: a 10-bit `remaining` value in seconds, plus a 10-bit `reload` value.
- Output digits are derived from `remaining`: `minutes0` = remaining/60; `seconds1` = (remaining%60)/10; `seconds0` = remaining%10. The upper bits of each digit output are zero.
- Load clamping is applied per digit before conversion:
  - `load_seconds0` > 9 becomes 9.
  - `load_seconds1` > 5 becomes 5.
  - `load_minutes0` > 9 becomes 9.
  - `remaining` = m×60 + s1×10 + s0.
- On load, `reload` captures the same clamped value.
- Decrement: `remaining` becomes remaining − step, saturating at 0. A `step` of 0 leaves the value unchanged but still keeps the FSM in RUN.
- FSM states and transitions:
  - IDLE: entered on reset. `count` is ignored. `load` with a non-zero value goes to PAUSE; `load` with 0:00 goes to EXPIRED with no `expired` pulse.
  - PAUSE: `count`=1 decrements on that edge and goes to RUN. If that decrement reaches 0, go to EXPIRED instead.
  - RUN: `count`=1 decrements. `count`=0 goes to PAUSE with the value held. Reaching 0 goes to EXPIRED.
  - EXPIRED: `count` is ignored and the value holds at 0:00. Only `load` or `reset` leaves this state.
  - `load` in any state: the new value applies on that edge, with no decrement on that edge. Next state is PAUSE, or EXPIRED if the value is 0.
- `expired` pulses exactly once per transition to zero caused by counting. Loading 0:00 never pulses.

## Timing
- Reset (asserted, `reset`=0): asynchronously clears `remaining`, `reload`, all digits, `running`, `done` and `expired` to 0, and forces state to IDLE. Leaving reset is synchronous to the next edge.
- Latency: the digits, `running`, `done` and `expired` all reflect an edge's action immediately after that same edge. There is no extra pipeline stage.
- `expired` is high for exactly the one cycle following the zero-reaching edge. `done` rises on that same edge.
- When `load` and `count` are both high, `load` wins and no decrement happens that cycle.
- When a saturating decrement hits 0, the result is 0 and there is no wrap to 9:59.

## Configuration
- Macro: `COUNTDOWN_AUTORELOAD_EN`.
- When defined: on a zero-reaching decrement with non-zero `reload`, `remaining` takes `reload` instead of 0. The state stays RUN, `expired` still pulses for one cycle, and `done` stays 0. With `reload` = 0, behaviour matches the undefined case.
- When undefined: the counter stops at 0:00 in EXPIRED.

## Structure
- Shared package `timer_pkg` holds:
  - `MAX_SECONDS` (599), the digit width (6) and the digit limits (9, 5, 9).
  - The FSM state encoding: IDLE, PAUSE, RUN, EXPIRED (2 bits).
- Sub-module `seconds_to_digits`: combinational conversion from 10-bit seconds to three 6-bit digits. It is shared with future `Timer` reworks. Its outputs feed the digit registers.

## Test plan
- Reset and IDLE: hold `reset`=0 with `count`=1 → all outputs 0. Release reset for 10 cycles with no load → digits stay 0:00, `running`=0, `done`=0.
- Basic countdown: load 1:30, `step`=1, `count`=1 → 1:29 after the first enabled edge, 0:00 after 90 edges. `expired` is high for exactly 1 cycle, and `done`=1 afterwards while `count` stays high.
- Pause and resume:
  - Start from 1:00 and let 5 edges run → 0:55.
  - Set `count`=0 for 20 cycles → holds 0:55, `running`=0.
  - Set `count`=1 → 0:54 on the next edge.
- Large step with saturation: load 0:40, `step`=15 → 0:25, then 0:10, then 0:00. Exactly one `expired` pulse. Then set `step`=1 → stays 0:00.
- Load priority and reset mid-run:
  - While running at 0:50, assert `load`=1 with 2:00 and `count`=1 → shows 2:00 (not 1:59).
  - Pull `reset` low mid-cycle → digits read 0:00 before the next edge.
- Clamping and autoreload:
  - Load digits 12/7/12 → 9:59.
  - With `COUNTDOWN_AUTORELOAD_EN` defined, load 0:03 and `step`=1 → sequence 0:02, 0:01, then 0:03 with an `expired` pulse and `done`=0. Without the macro, the same sequence stops at 0:00 with `done`=1.
